serial_parity_frame_receiver: RTL and testbench

SERIAL_PARITY_FRAME_RECEIVER -- requirements
Module: serial_parity_frame_receiver

---
 rtl/serial_parity_frame_receiver.sv | 123 ++++++++++++
 tb/tb_serial_parity_frame_receiver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_frame_receiver.sv
// Serial frame receiver: start(0), X, Y, Z, P, stop(1), sampled on Sample_en strobes.
// A good frame is held on X/Y/Z/P with Valid until Ack. Parity is left to the downstream checker.
module serial_parity_frame_receiver (
  input  logic Clock,
  input  logic Reset_b,
  input  logic Sample_en,
  input  logic Rx,
  input  logic Ack,
  output logic X,
  output logic Y,
  output logic Z,
  output logic P,
  output logic Valid,
  output logic Frame_err,
  output logic Overrun,
  output logic Busy
);

  // state | meaning
  // IDLE  | line idle, waiting for a sampled start bit (Rx=0)
  // DATA  | capturing X,Y,Z,P into the shift register, slot = cnt_q
  // STOP  | expecting stop bit; 1 delivers the frame, 0 flags Frame_err
  // HOLD  | frame presented with Valid=1 until Ack
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  shift_q, shift_d;   // bit 0 = X ... bit 3 = P
  logic [3:0]  data_q, data_d;     // delivered frame, same bit order
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      shift_q <= 4'd0;
      data_q  <= 4'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state and datapath updates; pulses default low so they last one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Sample_en && !Rx) begin
          state_d = DATA;
          cnt_d   = 2'd0;
        end
      end
      DATA: begin
        if (Sample_en) begin
          shift_d[cnt_q] = Rx;
          cnt_d          = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (Sample_en) begin
          if (Rx) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            ferr_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        // A start bit here cannot be captured: the held frame has not been consumed.
        if (Sample_en && !Rx) begin
          ovr_d = 1'b1;
        end
        // Ack exits regardless of Sample_en; the colliding start bit is dropped.
        if (Ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign X         = data_q[0];
  assign Y         = data_q[1];
  assign Z         = data_q[2];
  assign P         = data_q[3];
  assign Valid     = valid_q;
  assign Frame_err = ferr_q;
  assign Overrun   = ovr_q;
  assign Busy      = (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_serial_parity_frame_receiver.sv
// Scoreboard bench: expected events are queued as frames are driven and
// popped by a monitor when the receiver reports Valid, Frame_err or Overrun.
module tb_serial_parity_frame_receiver;

  logic Clock = 1'b0;
  logic Reset_b = 1'b0;
  logic Sample_en = 1'b0;
  logic Rx = 1'b1;
  logic Ack = 1'b0;
  logic X, Y, Z, P, Valid, Frame_err, Overrun, Busy;

  serial_parity_frame_receiver dut (
    .Clock(Clock), .Reset_b(Reset_b), .Sample_en(Sample_en), .Rx(Rx), .Ack(Ack),
    .X(X), .Y(Y), .Z(Z), .P(P), .Valid(Valid),
    .Frame_err(Frame_err), .Overrun(Overrun), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  localparam logic [1:0] EV_FRAME = 2'd0;
  localparam logic [1:0] EV_FERR  = 2'd1;
  localparam logic [1:0] EV_OVR   = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] xyzp;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic step(input logic rx, input logic en, input logic ack);
    @(negedge Clock);
    Rx = rx;
    Sample_en = en;
    Ack = ack;
  endtask

  // bits[0] is sent first; with gaps, two disabled cycles carrying the inverted bit follow each bit.
  task automatic send(input logic [0:5] bits, input bit gaps);
    for (int i = 0; i < 6; i++) begin
      step(bits[i], 1'b1, 1'b0);
      if (i > 0) chk("busy_in_frame", Busy, 1);
      if (gaps && i < 5) begin
        step(~bits[i], 1'b0, 1'b0);
        step(~bits[i], 1'b0, 1'b0);
      end
    end
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [1:0] kind, input logic [3:0] xyzp);
    ev_t e;
    e.kind = kind;
    e.xyzp = xyzp;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are read on the falling edge, half a cycle after they change.
  logic prev_valid = 1'b0;
  logic prev_ferr = 1'b0;
  logic prev_ovr = 1'b0;
  always @(negedge Clock) begin
    ev_t e;
    if (Reset_b) begin
      if (Valid && !prev_valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("valid_event_kind", {6'd0, e.kind}, {6'd0, EV_FRAME});
          chk("frame_xyzp", {4'd0, X, Y, Z, P}, {4'd0, e.xyzp});
        end
      end
      if (Frame_err) begin
        if (prev_ferr) chk("frame_err_width", 1, 0);
        else if (exp_q.size() == 0) chk("unexpected_frame_err", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("frame_err_kind", {6'd0, EV_FERR}, {6'd0, e.kind});
        end
      end
      if (Overrun) begin
        if (prev_ovr) chk("overrun_width", 1, 0);
        else if (exp_q.size() == 0) chk("unexpected_overrun", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("overrun_kind", {6'd0, EV_OVR}, {6'd0, e.kind});
        end
      end
    end
    prev_valid <= Valid;
    prev_ferr  <= Frame_err;
    prev_ovr   <= Overrun;
  end

  task automatic ack_frame();
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("valid_after_ack", Valid, 0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_xyzp", {4'd0, X, Y, Z, P}, 0);
    chk("rst_valid", Valid, 0);
    chk("rst_ferr", Frame_err, 0);
    chk("rst_ovr", Overrun, 0);
    chk("rst_busy", Busy, 0);
    @(negedge Clock);
    Reset_b = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("idle_busy", Busy, 0);

    // Basic frame 0,1,0,1,1,1 -> XYZP=1011, odd parity reaches the checker
    push(EV_FRAME, 4'b1011);
    send(6'b010111, 1'b0);
    chk("valid_after_6", Valid, 1);
    chk("busy_in_hold", Busy, 0);
    chk("checker_c", X ^ Y ^ Z ^ P, 1);

    // Held for 5 cycles without Ack, then consumed
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("valid_held", Valid, 1);
    end
    ack_frame();
    chk("xyzp_after_ack", {4'd0, X, Y, Z, P}, {4'd0, 4'b1011});

    // Bad stop bit: Frame_err pulse, outputs untouched
    push(EV_FERR, 4'b0000);
    send(6'b011000, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("ferr_valid", Valid, 0);
    chk("ferr_xyzp", {4'd0, X, Y, Z, P}, {4'd0, 4'b1011});
    chk("ferr_busy", Busy, 0);

    // All-zero frame held, then a start bit before Ack -> Overrun
    push(EV_FRAME, 4'b0000);
    send(6'b000001, 1'b0);
    push(EV_OVR, 4'b0000);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("ovr_valid_kept", Valid, 1);
    chk("ovr_xyzp", {4'd0, X, Y, Z, P}, {4'd0, 4'b0000});
    ack_frame();

    // Ack colliding with a start bit in HOLD: Ack wins, start bit lost
    push(EV_FRAME, 4'b1101);
    send(6'b011011, 1'b0);
    push(EV_OVR, 4'b0000);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("collide_valid", Valid, 0);
    chk("collide_busy", Busy, 0);
    step(1'b1, 1'b1, 1'b0);
    chk("collide_still_idle", Busy, 0);

    // Ack while nothing is held does nothing
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("stray_ack_valid", Valid, 0);
    chk("stray_ack_xyzp", {4'd0, X, Y, Z, P}, {4'd0, 4'b1101});

    // Gapped Sample_en gives the same result as the basic frame
    push(EV_FRAME, 4'b1011);
    send(6'b010111, 1'b1);
    chk("gapped_valid", Valid, 1);
    ack_frame();

    // Reset in the middle of a frame discards it
    push(EV_FRAME, 4'b0110);
    send(6'b001101, 1'b0);
    ack_frame();
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #2 Reset_b = 1'b0;
    #1;
    chk("midrst_xyzp", {4'd0, X, Y, Z, P}, 0);
    chk("midrst_busy", Busy, 0);
    chk("midrst_valid", Valid, 0);
    @(negedge Clock);
    Reset_b = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    chk("post_rst_valid", Valid, 0);
    chk("post_rst_busy", Busy, 0);
    push(EV_FRAME, 4'b0101);
    send(6'b001011, 1'b0);
    chk("post_rst_frame_valid", Valid, 1);
    ack_frame();

    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
